wb_regfile: RTL and testbench

//  Write-back end of the pipeline: register file consuming the stage-3 result bus
//  (write data, write select, write enable) and serving two combinational read ports to decode.

---
 rtl/pipe_pkg.sv | 9 +
 rtl/wb_scoreboard.sv | 68 ++++++
 rtl/wb_regfile.sv | 62 ++++++
 tb/tb_wb_regfile.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types and default widths for the write-back register file.
package pipe_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_PEND_W = 2;

  typedef logic [DEF_ADDR_W-1:0] reg_sel_t;
  typedef logic [DEF_DATA_W-1:0] word_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters, hazard lookup for both read ports, sticky overflow.
// WB_REGFILE_BYPASS_EN: hazard is suppressed while the last outstanding write lands.
module wb_scoreboard
  import pipe_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PEND_W = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_sel,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_sel,
  input  logic [ADDR_W-1:0] rd_sel_a,
  input  logic [ADDR_W-1:0] rd_sel_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              pend_ovf
);
  localparam int NREG = 2**ADDR_W;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [NREG-1:0][PEND_W-1:0] w_pend;
  logic [NREG-1:0]             w_ovf_hit;
  logic                        r_ovf;
  logic [PEND_W-1:0]           w_pend_a, w_pend_b;

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    logic              w_iss, w_wb;
    logic [PEND_W-1:0] r_cnt;

    // Register 0 is hardwired: never pending, never overflows.
    assign w_iss = iss_en && (iss_sel == ADDR_W'(g)) && (g != 0);
    assign w_wb  = wb_en  && (wb_sel  == ADDR_W'(g)) && (g != 0);

    always_ff @(posedge clk) begin
      if (reset)
        r_cnt <= '0;
      else if (w_iss && !w_wb) begin
        if (r_cnt != PEND_MAX) r_cnt <= r_cnt + 1'b1;
      end else if (w_wb && !w_iss) begin
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
    end

    assign w_pend[g]    = r_cnt;
    assign w_ovf_hit[g] = w_iss && !w_wb && (r_cnt == PEND_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset)           r_ovf <= 1'b0;
    else if (|w_ovf_hit) r_ovf <= 1'b1;
  end

  assign pend_ovf = r_ovf;
  assign w_pend_a = w_pend[rd_sel_a];
  assign w_pend_b = w_pend[rd_sel_b];

  always_comb begin
    hazard_a = (rd_sel_a != '0) && (w_pend_a != '0);
    hazard_b = (rd_sel_b != '0) && (w_pend_b != '0);
`ifdef WB_REGFILE_BYPASS_EN
    if (wb_en && wb_sel == rd_sel_a && w_pend_a == PEND_W'(1)) hazard_a = 1'b0;
    if (wb_en && wb_sel == rd_sel_b && w_pend_b == PEND_W'(1)) hazard_b = 1'b0;
`endif
  end
endmodule

// File: rtl/wb_regfile.sv
// Write-back register file with two combinational read ports and a pending-write scoreboard.
// WB_REGFILE_BYPASS_EN: same-cycle write-through from the write-back bus to the read ports.
module wb_regfile
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PEND_W = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_sel,
  input  logic [ADDR_W-1:0] rd_sel_a,
  input  logic [ADDR_W-1:0] rd_sel_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              pend_ovf
);
  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] r_regs [NREG];
  logic              w_wr;

  assign w_wr = wb_en && (wb_sel != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[wb_sel] <= wb_data;
    end
  end

  always_comb begin
    rd_data_a = (rd_sel_a == '0) ? '0 : r_regs[rd_sel_a];
    rd_data_b = (rd_sel_b == '0) ? '0 : r_regs[rd_sel_b];
`ifdef WB_REGFILE_BYPASS_EN
    if (w_wr && wb_sel == rd_sel_a) rd_data_a = wb_data;
    if (w_wr && wb_sel == rd_sel_b) rd_data_b = wb_data;
`endif
  end

  wb_scoreboard #(.ADDR_W(ADDR_W), .PEND_W(PEND_W)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .wb_en    (wb_en),
    .wb_sel   (wb_sel),
    .iss_en   (iss_en),
    .iss_sel  (iss_sel),
    .rd_sel_a (rd_sel_a),
    .rd_sel_b (rd_sel_b),
    .hazard_a (hazard_a),
    .hazard_b (hazard_b),
    .pend_ovf (pend_ovf)
  );
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; expectations follow WB_REGFILE_BYPASS_EN when defined.
module tb_wb_regfile;
  import pipe_pkg::*;

`ifdef WB_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic     clk = 1'b0;
  logic     reset;
  logic     wb_en, iss_en;
  reg_sel_t wb_sel, iss_sel, rd_sel_a, rd_sel_b;
  word_t    wb_data, rd_data_a, rd_data_b;
  logic     hazard_a, hazard_b, pend_ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .reset(reset),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .iss_en(iss_en), .iss_sel(iss_sel),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .hazard_a(hazard_a), .hazard_b(hazard_b), .pend_ovf(pend_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; wb_en = 1'b0; wb_sel = '0; wb_data = '0;
    iss_en = 1'b0; iss_sel = '0;
  endtask

  initial begin
    idle();
    rd_sel_a = '0; rd_sel_b = '0;

    // 1: reset state
    reset = 1'b1;
    tick();
    idle();
    #1;
    for (int i = 0; i < 32; i++) begin
      rd_sel_a = reg_sel_t'(i);
      rd_sel_b = reg_sel_t'(31 - i);
      #1;
      chk("rst_rd_a", rd_data_a, 32'h0);
      chk("rst_rd_b", rd_data_b, 32'h0);
      chk("rst_hz",   {30'h0, hazard_a, hazard_b}, 32'h0);
    end
    chk("rst_ovf", {31'h0, pend_ovf}, 32'h0);

    // 2: write 5, same-cycle then next-cycle read
    wb_en = 1'b1; wb_sel = 5'd5; wb_data = 32'hDEADBEEF; rd_sel_a = 5'd5; rd_sel_b = 5'd6;
    #1;
    chk("wr5_same", rd_data_a, BYP ? 32'hDEADBEEF : 32'h0);
    chk("wr5_b6",   rd_data_b, 32'h0);
    tick();
    wb_sel = 5'd6; wb_data = 32'h0BADF00D;
    #1;
    chk("wr5_next", rd_data_a, 32'hDEADBEEF);
    tick();
    idle();
    #1;
    chk("wr6_next", rd_data_b, 32'h0BADF00D);
    chk("wr5_keep", rd_data_a, 32'hDEADBEEF);

    // 3: register 0 is immutable and never pending
    wb_en = 1'b1; wb_sel = 5'd0; wb_data = 32'h1234; rd_sel_a = 5'd0;
    #1;
    chk("r0_same", rd_data_a, 32'h0);
    tick();
    idle();
    iss_en = 1'b1; iss_sel = 5'd0;
    #1;
    chk("r0_rd", rd_data_a, 32'h0);
    tick();
    idle();
    #1;
    chk("r0_hz", {31'h0, hazard_a}, 32'h0);

    // 4: issue 7 at cyc0, write back at cyc2
    iss_en = 1'b1; iss_sel = 5'd7; rd_sel_a = 5'd7;
    #1;
    chk("hz7_c0", {31'h0, hazard_a}, 32'h0);
    tick();
    idle();
    #1;
    chk("hz7_c1", {31'h0, hazard_a}, 32'h1);
    tick();
    wb_en = 1'b1; wb_sel = 5'd7; wb_data = 32'h77;
    #1;
    chk("hz7_c2",   {31'h0, hazard_a}, BYP ? 32'h0 : 32'h1);
    chk("rd7_c2",   rd_data_a, BYP ? 32'h77 : 32'h0);
    tick();
    idle();
    #1;
    chk("hz7_c3", {31'h0, hazard_a}, 32'h0);
    chk("rd7_c3", rd_data_a, 32'h77);

    // 5: saturate 9; iss+wb at max is net zero without overflow
    rd_sel_b = 5'd9;
    for (int k = 0; k < 3; k++) begin
      iss_en = 1'b1; iss_sel = 5'd9;
      tick();
    end
    idle();
    #1;
    chk("sat_hz",   {31'h0, hazard_b}, 32'h1);
    chk("sat_ovf0", {31'h0, pend_ovf}, 32'h0);
    iss_en = 1'b1; iss_sel = 5'd9; wb_en = 1'b1; wb_sel = 5'd9; wb_data = 32'h900;
    tick();
    idle();
    #1;
    chk("both_ovf", {31'h0, pend_ovf}, 32'h0);
    chk("both_rd",  rd_data_b, 32'h900);
    iss_en = 1'b1; iss_sel = 5'd9;
    tick();
    idle();
    #1;
    chk("sat_ovf1", {31'h0, pend_ovf}, 32'h1);
    // count must be exactly 3: two drains keep hazard, third clears it
    for (int k = 0; k < 3; k++) begin
      wb_en = 1'b1; wb_sel = 5'd9; wb_data = 32'h901 + k;
      tick();
      idle();
      #1;
      chk("drain_hz", {31'h0, hazard_b}, (k < 2) ? 32'h1 : 32'h0);
    end
    chk("drain_rd", rd_data_b, 32'h903);
    chk("ovf_stk",  {31'h0, pend_ovf}, 32'h1);

    // stray write-back holds the counter at zero
    rd_sel_a = 5'd11;
    wb_en = 1'b1; wb_sel = 5'd11; wb_data = 32'hB;
    tick();
    idle();
    iss_en = 1'b1; iss_sel = 5'd11;
    tick();
    idle();
    #1;
    chk("stray_hz1", {31'h0, hazard_a}, 32'h1);
    wb_en = 1'b1; wb_sel = 5'd11; wb_data = 32'hBB;
    tick();
    idle();
    #1;
    chk("stray_hz0", {31'h0, hazard_a}, 32'h0);

    // 6: reset wins over a pending issue and a same-cycle write-back
    wb_en = 1'b1; wb_sel = 5'd4; wb_data = 32'h44;
    tick();
    idle();
    iss_en = 1'b1; iss_sel = 5'd4; rd_sel_a = 5'd4;
    tick();
    idle();
    #1;
    chk("r4_pre_hz", {31'h0, hazard_a}, 32'h1);
    chk("r4_pre_rd", rd_data_a, 32'h44);
    reset = 1'b1; wb_en = 1'b1; wb_sel = 5'd4; wb_data = 32'h99;
    iss_en = 1'b1; iss_sel = 5'd4;
    tick();
    idle();
    #1;
    chk("r4_rst_hz",  {31'h0, hazard_a}, 32'h0);
    chk("r4_rst_rd",  rd_data_a, 32'h0);
    chk("r4_rst_ovf", {31'h0, pend_ovf}, 32'h0);
    chk("r9_rst_rd",  rd_data_b, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
